alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Multi-cycle issue/writeback sequencer: the initiator side of the ALU
//  interface. Accepts one instruction per handshake, reads a 32x32 register file,
//  drives ALU op/func/A/B, captures LOW/HIGH and writes them back. Sits between
//  instruction fetch and the combinational ALU in the KGP-RISC datapath.
// PARAMETERS
//  NREG   32  register count; fixed at 32 because addresses are 5 bits.
//  IMMW   10  immediate field width; sign-extended to 32 bits.
// PORTS
//  clk          in   1   single clock; all state updates on the rising edge
//  rst          in   1   asynchronous, active-high reset
//  instr_valid  in   1   instr holds a valid instruction
//  instr_ready  out  1   block can accept an instruction (IDLE only)
//  instr        in   32  [31:30] op, [29:26] func, [25:21] rs, [20:16] rt,
//                        [15:11] rd, [10] imm_sel, [9:0] imm
//  op_code      out  2   to ALU, registered
//  func_code    out  4   to ALU, registered
//  A            out  32  to ALU, registered: R[rs]
//  B            out  32  to ALU, registered: imm_sel ? sext(imm) : R[rt]
//  LOW          in   32  ALU low result
//  HIGH         in   32  ALU high result (multiply upper word or sign fill)
//  done         out  1   one-cycle pulse in the final writeback cycle
//  wb_addr      out  5   register written this cycle (valid while wb_en)
//  wb_data      out  32  data written this cycle
//  wb_en        out  1   write strobe (0 when target is r0)
//  dbg_addr     in   5   asynchronous debug read address
//  dbg_data     out  32  R[dbg_addr], combinational
// BEHAVIOUR
//  Reset: state=IDLE; all registers R0..R31=0; op_code, func_code, A, B,
//   wb_addr, wb_data=0; done, wb_en=0; instr_ready=1. Applies immediately and
//   aborts any in-flight instruction with no register write.
//  FSM: IDLE -> DECODE -> EXEC -> WB_LO -> (WB_HI if mul) -> IDLE.
//   IDLE:   instr_ready=1; on instr_valid&instr_ready latch instr -> DECODE.
//           No handshake -> stay in IDLE.
//   DECODE: load op_code, func_code, A, B from the latched instr and the regfile.
//   EXEC:   ALU settles; capture LOW->lo_q and HIGH->hi_q at the end of the cycle.
//   WB_LO:  wb_addr=rd, wb_data=lo_q, wb_en=(rd!=0). If mul, go to WB_HI.
//           Otherwise assert done and go to IDLE.
//   WB_HI:  wb_addr=rd+1 mod 32 (rd=31 wraps to 0), wb_data=hi_q,
//           wb_en=(addr!=0); assert done; go to IDLE.
//  mul means {op,func} = 6'b010001 or 6'b010010. Other codes are passed through
//   unmodified and write LOW only.
//  Latency from acceptance edge T: non-mul commits at edge T+3 and instr_ready=1
//   from T+3; mul commits low at T+3 and high at T+4, instr_ready=1 from T+4.
//  Register reads in DECODE see all prior writes, because writeback completes
//   before the next acceptance; no forwarding is needed.
//  r0 reads return 0 always; writes to r0 are suppressed with wb_en=0, but done
//   still pulses.
//  instr_valid while not ready is ignored and instr is not latched; the upstream
//   holds it.
//  dbg_data reflects a write the cycle after the commit edge.
// TESTING
//  1 reset: assert rst mid-EXEC -> instr_ready=1, no wb_en, dbg R[any]=0.
//  2 add-imm: R1=0; {op,func}=000000, rd=1, rs=0, imm_sel=1, imm=10'h3FF
//    -> B=32'hFFFFFFFF; ALU LOW=FFFFFFFF written to R1 at T+3; done pulse.
//  3 mul: R2=7, R3=-3; {op,func}=010010, rd=4; drive LOW=FFFFFFEB, HIGH=FFFFFFFF
//    -> R4=FFFFFFEB at T+3, R5=FFFFFFFF at T+4; single done at T+4.
//  4 wrap: mul with rd=31 -> R31=LOW, high write targets r0 with wb_en=0,
//    R0 remains 0.
//  5 back-to-back: instr_valid held high for 3 instrs, second reads the first's
//    rd -> each accepted only in IDLE, second sees the updated value.
//  6 r0 dest: and to rd=0 -> wb_en=0, done=1, all registers unchanged.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for the KGP-RISC ALU: accepts one instruction, reads
// the 32x32 register file, drives the ALU, then writes LOW (and HIGH for mul) back.
module alu_issue_ctrl #(
    parameter int NREG = 32,
    parameter int IMMW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [1:0]  op_code,
    output logic [3:0]  func_code,
    output logic [31:0] A,
    output logic [31:0] B,
    input  logic [31:0] LOW,
    input  logic [31:0] HIGH,
    output logic        done,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        wb_en,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB_LO  = 3'd3,
        S_WB_HI  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q;
    logic [1:0]  op_q;
    logic [3:0]  func_q;
    logic [31:0] a_q, b_q, lo_q, hi_q;
    logic [31:0] regs_q [NREG];

    logic [1:0]  f_op;
    logic [3:0]  f_func;
    logic [4:0]  f_rs, f_rt, f_rd, f_rd_hi;
    logic        f_imm_sel, is_mul, accept;
    logic [31:0] imm_sext, rs_val, rt_val;

    assign f_op      = instr_q[31:30];
    assign f_func    = instr_q[29:26];
    assign f_rs      = instr_q[25:21];
    assign f_rt      = instr_q[20:16];
    assign f_rd      = instr_q[15:11];
    assign f_imm_sel = instr_q[10];
    assign f_rd_hi   = f_rd + 5'd1;
    assign imm_sext  = {{(32-IMMW){instr_q[IMMW-1]}}, instr_q[IMMW-1:0]};
    assign is_mul    = ({f_op, f_func} == 6'b010001) || ({f_op, f_func} == 6'b010010);
    assign rs_val    = (f_rs == 5'd0) ? 32'd0 : regs_q[f_rs];
    assign rt_val    = (f_rt == 5'd0) ? 32'd0 : regs_q[f_rt];

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both high; instr_ready is high only in IDLE, and the upstream
    // must hold instr stable until that edge.
    assign accept = instr_valid && instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB_LO;
            S_WB_LO:  state_d = is_mul ? S_WB_HI : S_IDLE;
            S_WB_HI:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        done        = 1'b0;
        wb_addr     = 5'd0;
        wb_data     = 32'd0;
        wb_en       = 1'b0;
        unique case (state_q)
            S_IDLE: instr_ready = 1'b1;
            S_WB_LO: begin
                wb_addr = f_rd;
                wb_data = lo_q;
                wb_en   = (f_rd != 5'd0);
                done    = !is_mul;
            end
            S_WB_HI: begin
                wb_addr = f_rd_hi;
                wb_data = hi_q;
                wb_en   = (f_rd_hi != 5'd0);
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= 32'd0;
            op_q    <= 2'd0;
            func_q  <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            lo_q    <= 32'd0;
            hi_q    <= 32'd0;
        end else begin
            if (accept) instr_q <= instr;
            if (state_q == S_DECODE) begin
                op_q   <= f_op;
                func_q <= f_func;
                a_q    <= rs_val;
                b_q    <= f_imm_sel ? imm_sext : rt_val;
            end
            if (state_q == S_EXEC) begin
                lo_q <= LOW;
                hi_q <= HIGH;
            end
        end
    end

    // r0 is never written (wb_en excludes it), so it stays at its reset value of 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= 32'd0;
        end else if (wb_en) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    assign op_code   = op_q;
    assign func_code = func_q;
    assign A         = a_q;
    assign B         = b_q;
    assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: the bench plays the ALU and checks every cycle of
// each instruction against a register-file model built from the instruction rules.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [1:0]  op_code;
  logic [3:0]  func_code;
  logic [31:0] A, B;
  logic [31:0] LOW = '0, HIGH = '0;
  logic        done;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_en;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] model_r [32];

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .op_code(op_code), .func_code(func_code), .A(A), .B(B),
    .LOW(LOW), .HIGH(HIGH), .done(done), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_en(wb_en), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [3:0] fn,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic isel,
                                     input logic [9:0] imm);
    return {op, fn, rs, rt, rd, isel, imm};
  endfunction

  // Issue one instruction and check every cycle of its life. hold keeps
  // instr_valid high afterwards with junk on instr, as a busy upstream would.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] lo,
                           input logic [31:0] hi, input bit hold);
    logic [1:0]  op  = ins[31:30];
    logic [3:0]  fn  = ins[29:26];
    logic [4:0]  rs  = ins[25:21];
    logic [4:0]  rt  = ins[20:16];
    logic [4:0]  rd  = ins[15:11];
    logic [9:0]  imm = ins[9:0];
    logic [4:0]  rd_hi;
    logic [31:0] exp_a, exp_b;
    bit          mul;
    int          n = 0;
    mul   = ({op, fn} == 6'b010001) || ({op, fn} == 6'b010010);
    rd_hi = 5'((int'(rd) + 1) % 32);
    exp_a = model_r[rs];
    exp_b = ins[10] ? {{22{imm[9]}}, imm} : model_r[rt];
    while (instr_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    nvec++;
    if (instr_ready !== 1'b1) begin $display("FAIL ready_wait: instr_ready=%b after %0d cycles, required 1", instr_ready, n); nerr++; end
    instr = ins; instr_valid = 1'b1; LOW = lo; HIGH = hi;
    @(negedge clk);
    if (hold) instr = $urandom; else instr_valid = 1'b0;
    nvec++; if (instr_ready !== 1'b0) begin $display("FAIL decode_ready: got %b required 0", instr_ready); nerr++; end
    nvec++; if (wb_en !== 1'b0 || done !== 1'b0) begin $display("FAIL decode_quiet: wb_en=%b done=%b required 0 0", wb_en, done); nerr++; end
    @(negedge clk);
    nvec++; if (op_code !== op) begin $display("FAIL op_code: got %h required %h", op_code, op); nerr++; end
    nvec++; if (func_code !== fn) begin $display("FAIL func_code: got %h required %h", func_code, fn); nerr++; end
    nvec++; if (A !== exp_a) begin $display("FAIL operand_a: got %h required %h", A, exp_a); nerr++; end
    nvec++; if (B !== exp_b) begin $display("FAIL operand_b: got %h required %h", B, exp_b); nerr++; end
    nvec++; if (instr_ready !== 1'b0) begin $display("FAIL exec_ready: got %b required 0", instr_ready); nerr++; end
    @(negedge clk);
    LOW = ~lo; HIGH = ~hi;
    nvec++; if (wb_en !== (rd != 5'd0)) begin $display("FAIL wb_lo_en: got %b required %b", wb_en, rd != 5'd0); nerr++; end
    nvec++; if (wb_addr !== rd) begin $display("FAIL wb_lo_addr: got %0d required %0d", wb_addr, rd); nerr++; end
    nvec++; if (wb_data !== lo) begin $display("FAIL wb_lo_data: got %h required %h", wb_data, lo); nerr++; end
    nvec++; if (done !== !mul) begin $display("FAIL wb_lo_done: got %b required %b", done, !mul); nerr++; end
    nvec++; if (instr_ready !== 1'b0) begin $display("FAIL wb_lo_ready: got %b required 0", instr_ready); nerr++; end
    if (rd != 5'd0) model_r[rd] = lo;
    @(negedge clk);
    if (mul) begin
      nvec++; if (wb_en !== (rd_hi != 5'd0)) begin $display("FAIL wb_hi_en: got %b required %b", wb_en, rd_hi != 5'd0); nerr++; end
      nvec++; if (wb_addr !== rd_hi) begin $display("FAIL wb_hi_addr: got %0d required %0d", wb_addr, rd_hi); nerr++; end
      nvec++; if (wb_data !== hi) begin $display("FAIL wb_hi_data: got %h required %h", wb_data, hi); nerr++; end
      nvec++; if (done !== 1'b1 || instr_ready !== 1'b0) begin $display("FAIL wb_hi_done: done=%b ready=%b required 1 0", done, instr_ready); nerr++; end
      if (rd_hi != 5'd0) model_r[rd_hi] = hi;
      @(negedge clk);
    end
    nvec++; if (instr_ready !== 1'b1 || done !== 1'b0 || wb_en !== 1'b0) begin $display("FAIL back_idle: ready=%b done=%b wb_en=%b required 1 0 0", instr_ready, done, wb_en); nerr++; end
    dbg_addr = rd; #1;
    nvec++; if (dbg_data !== model_r[rd]) begin $display("FAIL dbg_rd: R[%0d] got %h required %h", rd, dbg_data, model_r[rd]); nerr++; end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      nvec++;
      if (dbg_data !== model_r[i]) begin $display("FAIL %s: R[%0d] got %h required %h", tag, i, dbg_data, model_r[i]); nerr++; end
    end
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [9:0] imm);
    run_instr(mk(2'b00, 4'b0000, 5'd0, 5'd0, r, 1'b1, imm), {{22{imm[9]}}, imm}, 32'd0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1; instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    nvec++; if (instr_ready !== 1'b1) begin $display("FAIL rst_ready: got %b required 1", instr_ready); nerr++; end
    nvec++; if (done !== 1'b0 || wb_en !== 1'b0) begin $display("FAIL rst_strobes: done=%b wb_en=%b required 0 0", done, wb_en); nerr++; end
    nvec++; if ({op_code, func_code} !== 6'd0 || A !== 32'd0 || B !== 32'd0) begin $display("FAIL rst_alu_out: op=%h fn=%h A=%h B=%h required zeros", op_code, func_code, A, B); nerr++; end
    nvec++; if (wb_addr !== 5'd0 || wb_data !== 32'd0) begin $display("FAIL rst_wb: addr=%h data=%h required zeros", wb_addr, wb_data); nerr++; end
    rst = 1'b0;
    @(negedge clk);
    check_all_regs("rst_regs");
  endtask

  task automatic test_add_imm;
    run_instr(mk(2'b00, 4'b0000, 5'd0, 5'd0, 5'd1, 1'b1, 10'h3FF), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_mul;
    write_reg(5'd2, 10'd7);
    write_reg(5'd3, 10'h3FD);
    run_instr(mk(2'b01, 4'b0010, 5'd2, 5'd3, 5'd4, 1'b0, 10'd0), 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
    check_all_regs("mul_regs");
  endtask

  task automatic test_wrap;
    run_instr(mk(2'b01, 4'b0001, 5'd4, 5'd2, 5'd31, 1'b0, 10'd0), 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
    check_all_regs("wrap_regs");
  endtask

  task automatic test_back_to_back;
    logic [31:0] v = $urandom;
    run_instr(mk(2'b00, 4'b0000, 5'd0, 5'd0, 5'd6, 1'b1, 10'h055), v, $urandom, 1'b1);
    run_instr(mk(2'b00, 4'b0001, 5'd6, 5'd6, 5'd7, 1'b0, 10'd0), v + 32'd3, $urandom, 1'b1);
    run_instr(mk(2'b01, 4'b0001, 5'd7, 5'd6, 5'd8, 1'b0, 10'd0), $urandom, $urandom, 1'b1);
    instr_valid = 1'b0;
    check_all_regs("b2b_regs");
  endtask

  task automatic test_r0_dest;
    run_instr(mk(2'b00, 4'b0100, 5'd6, 5'd7, 5'd0, 1'b0, 10'd0), 32'hCAFE_F00D, 32'h0, 1'b0);
    check_all_regs("r0_regs");
  endtask

  task automatic test_random;
    for (int k = 0; k < 30; k++) begin
      logic [31:0] ins = $urandom;
      if ($urandom_range(0, 2) == 0) ins[31:26] = ($urandom_range(0, 1) == 0) ? 6'b010001 : 6'b010010;
      run_instr(ins, $urandom, $urandom, k[0]);
    end
    instr_valid = 1'b0;
    check_all_regs("rand_regs");
  endtask

  task automatic test_reset_midexec;
    int n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    instr = mk(2'b01, 4'b0010, 5'd1, 5'd2, 5'd9, 1'b0, 10'd0); instr_valid = 1'b1;
    LOW = 32'h5555_AAAA; HIGH = 32'h1111_2222;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk); #2 rst = 1'b1; #1;
    nvec++; if (instr_ready !== 1'b1) begin $display("FAIL midrst_ready: got %b required 1", instr_ready); nerr++; end
    nvec++; if (wb_en !== 1'b0 || done !== 1'b0) begin $display("FAIL midrst_strobes: wb_en=%b done=%b required 0 0", wb_en, done); nerr++; end
    nvec++; if (A !== 32'd0 || B !== 32'd0) begin $display("FAIL midrst_ops: A=%h B=%h required 0 0", A, B); nerr++; end
    for (int i = 0; i < 32; i++) model_r[i] = 32'd0;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      nvec++; if (wb_en !== 1'b0 || instr_ready !== 1'b1) begin $display("FAIL midrst_after: wb_en=%b ready=%b required 0 1", wb_en, instr_ready); nerr++; end
    end
    check_all_regs("midrst_regs");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_r[i] = 32'd0;
    test_reset;
    test_add_imm;
    test_mul;
    test_wrap;
    test_back_to_back;
    test_r0_dest;
    test_random;
    test_reset_midexec;
    test_add_imm;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
